// File: rtl/pipe_stage_ctrl_pkg.sv
// Shared types for the RV32I pipeline sequencing controller.
// Holds the I-side and D-side handshake state encodings and the word/register types.
package pipe_stage_ctrl_pkg;

    typedef logic [31:0] rv32i_word;
    typedef logic [4:0]  rv32i_reg;

    // Fetch side: either waiting on the I-cache or holding an already fetched word.
    typedef enum logic {
        I_REQ  = 1'b0,
        I_HOLD = 1'b1
    } pipe_istate_t;

    // Memory side: idle, waiting on the D-cache, or access finished while the pipe is stalled.
    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_BUSY = 2'd1,
        D_DONE = 2'd2
    } pipe_dstate_t;

endpackage

// File: rtl/pipe_stage_ctrl_hazard.sv
// Load-use hazard compare: the EX-stage load writes a register the ID-stage instruction reads.
// Purely combinational so a forwarding unit can reuse it.
module pipe_hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    output logic             hazard
);

    // x0 is never a real destination, so it can never create a dependency.
    always_comb begin
        hazard = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Sequencing controller for the 5-stage RV32I pipeline: stage load enables,
// flush/bubble controls, I-cache/D-cache handshakes and a one-entry fetch buffer.
// Optional macro PIPE_STALL_PERF_EN adds four 32-bit stall/hazard/flush counters.
module pipe_stage_ctrl
    import pipe_stage_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             icache_resp,
    input  logic [XLEN-1:0]  icache_rdata,
    output logic             icache_read,
    output logic [XLEN-1:0]  if_instr,
    input  logic             dcache_resp,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             dcache_read,
    output logic             dcache_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             ex_br_taken,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
`ifdef PIPE_STALL_PERF_EN
    output logic [31:0]      icache_stall_cnt,
    output logic [31:0]      dcache_stall_cnt,
    output logic [31:0]      hazard_cnt,
    output logic [31:0]      flush_cnt,
`endif
    output logic             flush_id_ex
);

    pipe_istate_t    istate_q, istate_d;
    pipe_dstate_t    dstate_q, dstate_d;
    logic [XLEN-1:0] ibuf_q, ibuf_d;

    logic hazard;
    logic if_ready;
    logic mem_rw;
    logic mem_ready;
    logic advance;

    pipe_hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .hazard      (hazard)
    );

    // Both sides must be satisfied before any stage register may move.
    always_comb begin
        if_ready  = ((istate_q == I_REQ) && icache_resp) || (istate_q == I_HOLD);
        mem_rw    = mem_read || mem_write;
        mem_ready = !mem_rw || dcache_resp || (dstate_q == D_DONE);
        advance   = if_ready && mem_ready;
    end

    // Fetch side: park a returned word in ibuf whenever it cannot enter IF/ID this cycle.
    always_comb begin
        istate_d = istate_q;
        ibuf_d   = ibuf_q;
        case (istate_q)
            I_REQ: begin
                // A bubble cycle also parks the word, since IF/ID is frozen.
                if (icache_resp && (!advance || (hazard && !ex_br_taken))) begin
                    istate_d = I_HOLD;
                    ibuf_d   = icache_rdata;
                end
            end
            I_HOLD: begin
                // A taken branch discards the held word; a bubble keeps it.
                if (advance && (ex_br_taken || !hazard)) begin
                    istate_d = I_REQ;
                end
            end
            default: istate_d = I_REQ;
        endcase
    end

    // Memory side: remember a finished access so it is not re-issued while the fetch catches up.
    always_comb begin
        dstate_d = dstate_q;
        if (advance) begin
            dstate_d = D_IDLE;
        end else begin
            case (dstate_q)
                D_IDLE: begin
                    if (dcache_resp)     dstate_d = D_DONE;
                    else if (mem_rw)     dstate_d = D_BUSY;
                end
                D_BUSY: begin
                    if (dcache_resp)     dstate_d = D_DONE;
                end
                D_DONE:                  dstate_d = D_DONE;
                default:                 dstate_d = D_IDLE;
            endcase
        end
    end

    // Outputs: requests and stage controls; everything forced low while reset is asserted.
    always_comb begin
        icache_read  = 1'b0;
        if_instr     = '0;
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        load_pc      = 1'b0;
        load_if_id   = 1'b0;
        load_id_ex   = 1'b0;
        load_ex_mem  = 1'b0;
        load_mem_wb  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        if (!rst) begin
            icache_read  = (istate_q == I_REQ);
            if_instr     = (istate_q == I_HOLD) ? ibuf_q : icache_rdata;
            dcache_read  = mem_read  && (dstate_q != D_DONE);
            dcache_write = mem_write && (dstate_q != D_DONE);
            if (advance) begin
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
                if (ex_br_taken) begin
                    // Wrong-path instructions in IF/ID and ID/EX are squashed.
                    load_pc     = 1'b1;
                    load_if_id  = 1'b1;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (hazard) begin
                    // Freeze PC and IF/ID, insert one bubble into ID/EX.
                    flush_id_ex = 1'b1;
                end else begin
                    load_pc     = 1'b1;
                    load_if_id  = 1'b1;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            istate_q <= I_REQ;
            dstate_q <= D_IDLE;
            ibuf_q   <= '0;
        end else begin
            istate_q <= istate_d;
            dstate_q <= dstate_d;
            ibuf_q   <= ibuf_d;
        end
    end

`ifdef PIPE_STALL_PERF_EN
    // Event order: I-stall, D-stall, bubble, flush.
    logic [3:0]  perf_evt;
    logic [31:0] perf_cnt_q [4];
    logic [31:0] perf_cnt_d [4];

    // Classify each cycle into the counted events.
    always_comb begin
        perf_evt[0] = !if_ready;
        perf_evt[1] = !mem_ready;
        perf_evt[2] = advance && hazard && !ex_br_taken;
        perf_evt[3] = advance && ex_br_taken;
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_perf
        assign perf_cnt_d[gi] = perf_cnt_q[gi] + {31'd0, perf_evt[gi]};
    end

    // Free-running counters, wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) perf_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) perf_cnt_q[i] <= perf_cnt_d[i];
        end
    end

    assign icache_stall_cnt = perf_cnt_q[0];
    assign dcache_stall_cnt = perf_cnt_q[1];
    assign hazard_cnt       = perf_cnt_q[2];
    assign flush_cnt        = perf_cnt_q[3];
`endif

endmodule
